// File: rtl/led_pkg.sv
// Shared definitions for the LED stages: envelope phase encoding, LED count
// and board clock rate.
package led_pkg;

    // Breathing envelope states; the encoding is visible on the phase port.
    typedef enum logic [1:0] {
        RAMP_UP   = 2'd0,
        HOLD_HI   = 2'd1,
        RAMP_DOWN = 2'd2,
        HOLD_LO   = 2'd3
    } phase_t;

    localparam int LED_NUM = 4;
    localparam int CLK_HZ  = 25_000_000;

endpackage

// File: rtl/tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks. A synchronous clear
// restarts the count from zero, so the next tick lands DIV clocks after
// the clear drops. DIV=1 gives a tick on every cycle.
module tick_gen #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int             CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;

    // Tick on the last count; suppressed while cleared.
    assign tick = (cnt == LAST) && !clr;

    // Count 0..DIV-1 and wrap; reset and clear both restart from zero.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples the pre-edge values and simulation matches the flops.
        if (rst || clr) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_breathe_pwm.sv
// LED breathing stage: registers the four blink-stage LED requests and, while
// breathe_en is high, PWM-dims the lit ones along a ramp-up / hold / ramp-down
// / hold envelope. With breathe_en low the requests pass through undimmed.
// Define LED_BREATHE_GAMMA_EN to apply a squared (gamma-2) duty curve to the
// PWM compare; the duty port always reports the linear value.
import led_pkg::*;

module led_breathe_pwm #(
    parameter int PWM_BITS   = 8,
    parameter int STEP_TICKS = 48828,
    parameter int HOLD_STEPS = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [LED_NUM-1:0]  led_in,
    input  logic                breathe_en,
    output logic [LED_NUM-1:0]  led_out,
    output logic [PWM_BITS-1:0] duty,
    output logic [1:0]          phase
);

    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);
    localparam int                  HOLD_W    = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HOLD_W-1:0]   HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

    phase_t              state_q, state_d;
    logic [PWM_BITS-1:0] duty_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [PWM_BITS-1:0] eff_duty;
    logic [LED_NUM-1:0]  led_in_q;
    logic                step;
    logic                pwm_on;

    // Envelope step prescaler; held at zero while breathing is disabled so a
    // re-enable always waits a full step before the first duty change.
    tick_gen #(
        .DIV (STEP_TICKS)
    ) u_step_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (!breathe_en),
        .tick (step)
    );

    // Envelope state, duty and hold counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RAMP_UP;
            duty    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            duty    <= duty_d;
            hold_q  <= hold_d;
        end
    end

    // Next envelope state: disable forces a dark restart, otherwise advance
    // one envelope step per tick.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        duty_d  = duty;
        hold_d  = hold_q;
        if (!breathe_en) begin
            state_d = RAMP_UP;
            duty_d  = '0;
            hold_d  = '0;
        end else if (step) begin
            unique case (state_q)
                RAMP_UP: begin
                    duty_d = duty + 1'b1;
                    if (duty == DUTY_MAX - DUTY_ONE) begin
                        state_d = HOLD_HI;
                        hold_d  = '0;
                    end
                end
                HOLD_HI: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RAMP_DOWN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    duty_d = duty - 1'b1;
                    if (duty == DUTY_ONE) begin
                        state_d = HOLD_LO;
                        hold_d  = '0;
                    end
                end
                HOLD_LO: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RAMP_UP;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: begin
                    state_d = RAMP_UP;
                    duty_d  = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    assign phase = state_q;

`ifdef LED_BREATHE_GAMMA_EN
    // Squared duty, truncated back to PWM_BITS, for a perceptually even ramp.
    logic [2*PWM_BITS-1:0] duty_ext;
    assign duty_ext = {{PWM_BITS{1'b0}}, duty};
    assign eff_duty = PWM_BITS'((duty_ext * duty_ext) >> PWM_BITS);
`else
    assign eff_duty = duty;
`endif

    assign pwm_on = (pwm_cnt < eff_duty);

    // Input register, free-running PWM counter and registered LED drive.
    always_ff @(posedge clk) begin
        if (rst) begin
            led_in_q <= '0;
            pwm_cnt  <= '0;
            led_out  <= '0;
        end else begin
            led_in_q <= led_in;
            pwm_cnt  <= pwm_cnt + 1'b1;
            if (breathe_en) begin
                led_out <= led_in_q & {LED_NUM{pwm_on}};
            end else begin
                led_out <= led_in_q;
            end
        end
    end

endmodule

// File: tb/tb_led_breathe_pwm.sv
// Scoreboard bench for led_breathe_pwm at PWM_BITS=4, STEP_TICKS=4,
// HOLD_STEPS=2. The stimulus process pushes expected outputs tagged with the
// clock edge they belong to; a monitor on the falling edge pops and compares.
module tb_led_breathe_pwm;

    localparam int PWM_BITS   = 4;
    localparam int STEP_TICKS = 4;
    localparam int HOLD_STEPS = 2;
    localparam int RAMP_STEPS = 15;                             // 0->15 and 15->0
    localparam int ENV_STEPS  = 2 * RAMP_STEPS + 2 * HOLD_STEPS; // 34 steps = 136 clks

    logic                clk;
    logic                rst;
    logic [3:0]          led_in;
    logic                breathe_en;
    logic [3:0]          led_out;
    logic [PWM_BITS-1:0] duty;
    logic [1:0]          phase;

    led_breathe_pwm #(
        .PWM_BITS   (PWM_BITS),
        .STEP_TICKS (STEP_TICKS),
        .HOLD_STEPS (HOLD_STEPS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .led_in     (led_in),
        .breathe_en (breathe_en),
        .led_out    (led_out),
        .duty       (duty),
        .phase      (phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising-edge index: after the n-th posedge cyc == n.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int       cyc;
        string    name;
        bit       chk_led;
        logic [3:0] led;
        bit       chk_dp;
        int       duty;
        int       phase;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int at, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, at, act, req);
        end
    endtask

    // Monitor: compare every entry due at the current edge; flag stale ones.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            check({mon_e.name, "_missed"}, cyc, mon_e.cyc, cyc);
        end
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            if (mon_e.chk_led)
                check({mon_e.name, "_led_out"}, cyc, 32'(led_out), 32'(mon_e.led));
            if (mon_e.chk_dp) begin
                check({mon_e.name, "_duty"},  cyc, 32'(duty),  mon_e.duty);
                check({mon_e.name, "_phase"}, cyc, 32'(phase), mon_e.phase);
            end
        end
    end

    // Envelope position after s steps from dark: ramp up 0..14, hold high
    // (duty 15) 2 steps, ramp down 15..1, hold low (duty 0) 2 steps.
    function automatic void env(input int s, output int d, output int p);
        int m;
        m = s % ENV_STEPS;
        if (m < RAMP_STEPS) begin
            d = m;              p = 0;
        end else if (m < RAMP_STEPS + HOLD_STEPS) begin
            d = RAMP_STEPS;     p = 1;
        end else if (m < 2 * RAMP_STEPS + HOLD_STEPS) begin
            d = 2 * RAMP_STEPS + HOLD_STEPS - m; p = 2;
        end else begin
            d = 0;              p = 3;
        end
    endfunction

    function automatic int eff(input int d);
`ifdef LED_BREATHE_GAMMA_EN
        return (d * d) >> PWM_BITS;
`else
        return d;
`endif
    endfunction

    task automatic push(input int at, input string name, input bit chk_led,
                        input logic [3:0] led, input bit chk_dp, input int d, input int p);
        exp_t e;
        e.cyc = at; e.name = name; e.chk_led = chk_led; e.led = led;
        e.chk_dp = chk_dp; e.duty = d; e.phase = p;
        sb.push_back(e);
    endtask

    // Expectations for k = k_lo..k_hi edges after a dark start at edge base.
    // LED drive is predicted for the first ramp: before edge k the PWM count
    // is (k-1)%16 and the duty is (k-1)/4.
    task automatic push_env(input int base, input int k_lo, input int k_hi,
                            input int led_k_max, input logic [3:0] mask, input string name);
        int d, p;
        logic [3:0] l;
        for (int k = k_lo; k <= k_hi; k++) begin
            env(k / STEP_TICKS, d, p);
            l = (((k - 1) % 16) < eff((k - 1) / STEP_TICKS)) ? mask : 4'h0;
            push(base + k, name, (k <= led_k_max), l, 1'b1, d, p);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    int b1, b2, r;

    initial begin
        rst        = 1'b1;
        led_in     = 4'hF;
        breathe_en = 1'b1;

        // Reset held for three edges with all LEDs requested.
        for (int i = 1; i <= 3; i++) push(i, "reset", 1'b1, 4'h0, 1'b1, 0, 0);
        wait_cyc(3);
        rst = 1'b0;
        b1  = cyc;

        // Two full envelopes plus the start of a third, into HOLD_HI.
        push_env(b1, 1, 333, 60, 4'hF, "env");
        wait_cyc(b1 + 333);

        // Reset during HOLD_HI; change the LED pattern at the same time.
        rst    = 1'b1;
        led_in = 4'b0101;
        push(b1 + 334, "rst_hold", 1'b1, 4'h0, 1'b1, 0, 0);
        wait_cyc(b1 + 334);
        rst = 1'b0;
        b2  = cyc;

        // Ramp with LEDs 2 and 4 unrequested; they must never light.
        push_env(b2, 1, 39, 39, 4'b0101, "ramp_0101");
        wait_cyc(b2 + 39);

        // Disable at duty 9, on the edge that would also have stepped to 10.
        breathe_en = 1'b0;
        push(b2 + 40, "disable", 1'b1, 4'b0101, 1'b1, 0, 0);
        wait_cyc(b2 + 40);

        // Pass-through: 0101 -> 0000 -> 1010, two-clock latency.
        led_in = 4'h0;
        push(b2 + 41, "pass", 1'b1, 4'b0101, 1'b1, 0, 0);
        push(b2 + 42, "pass", 1'b1, 4'h0,    1'b1, 0, 0);
        push(b2 + 43, "pass", 1'b1, 4'h0,    1'b1, 0, 0);
        wait_cyc(b2 + 43);
        led_in = 4'hA;
        push(b2 + 44, "pass", 1'b1, 4'h0, 1'b1, 0, 0);
        for (int i = 45; i <= 50; i++) push(b2 + i, "pass", 1'b1, 4'hA, 1'b1, 0, 0);
        wait_cyc(b2 + 50);

        // Re-enable: prescaler restarts, first step exactly 4 clocks later.
        breathe_en = 1'b1;
        r = cyc;
        push(r + 1, "reenable", 1'b1, 4'h0, 1'b1, 0, 0);
        push(r + 2, "reenable", 1'b0, 4'h0, 1'b1, 0, 0);
        push(r + 3, "reenable", 1'b0, 4'h0, 1'b1, 0, 0);
        push(r + 4, "reenable", 1'b0, 4'h0, 1'b1, 1, 0);

        for (int i = 0; i < 100 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) check("drain", cyc, sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/led_breathe_pwm.md
Name: led_breathe_pwm

Overview:
- Downstream stage of the 4-LED blink generator. Consumes its four on/off LED signals and drives the board LED pins.
- While `breathe_en` is high, each LED that is "on" is PWM-dimmed along a repeating breathing envelope: ramp up, hold, ramp down, hold.
- While `breathe_en` is low, the LED signals pass through registered and undimmed.
- Everything is on the single 25 MHz board clock.

Parameters:
- `PWM_BITS`, 8: PWM counter and duty width; PWM period is 2^PWM_BITS clocks.
- `STEP_TICKS`, 48828: clocks per envelope step. With the defaults, one 256-step ramp takes ≈0.5 s at 25 MHz. Must be ≥1.
- `HOLD_STEPS`, 64: envelope steps spent in each hold state. Must be ≥1.

Ports:
- `clk`: input, 1, 25 MHz board clock; sole clock.
- `rst`: input, 1, synchronous, active-high reset.
- `led_in`: input, 4, LED on/off requests from the blink stage; bit i maps to LED i+1.
- `breathe_en`: input, 1. 1 = breathing envelope applied; 0 = plain pass-through.
- `led_out`: output, 4, registered LED pin drive.
- `duty`: output, PWM_BITS, current envelope duty (status/debug).
- `phase`: output, 2, current envelope state encoding.

Behaviour:
- **Reset** (rst=1 at a clk edge, takes priority over everything):
  - `led_in_q`=0, `led_out`=0, `duty`=0, `phase`=RAMP_UP.
  - PWM counter=0, tick prescaler=0, hold counter=0.
  - Reset asserted mid-ramp or mid-hold aborts immediately. The first step after release occurs STEP_TICKS clocks later.
- **Input register:** `led_in_q` <= `led_in` every cycle.
- **PWM counter:**
  - `pwm_cnt` is free-running, 0..2^PWM_BITS-1, and wraps to 0.
  - It is not affected by `breathe_en`.
- **Step tick:**
  - Prescaler counts 0..STEP_TICKS-1.
  - `step` is a 1-cycle pulse when the count = STEP_TICKS-1; the count then wraps to 0.
  - With STEP_TICKS=1, `step` is asserted every cycle.
- **Envelope FSM** (advances only on `step`, and only when `breathe_en`=1). Encoding: RAMP_UP=0, HOLD_HI=1, RAMP_DOWN=2, HOLD_LO=3.
  - RAMP_UP: `duty`++. When `duty` reaches 2^PWM_BITS-1 (the increment that produces max), go to HOLD_HI with hold counter cleared.
  - HOLD_HI: hold counter++. On the HOLD_STEPS-th step, go to RAMP_DOWN.
  - RAMP_DOWN: `duty`--. When `duty` reaches 0, go to HOLD_LO with hold counter cleared.
  - HOLD_LO: hold counter++. On the HOLD_STEPS-th step, go to RAMP_UP.
  - `duty` never wraps: saturates at max and 0 by construction.
- **breathe_en=0:**
  - FSM is forced to RAMP_UP, `duty`=0, hold counter=0, prescaler=0.
  - Re-enabling therefore always starts the envelope from dark.
- **Output** (registered):
  - If `breathe_en`=1: `led_out[i]` <= `led_in_q[i]` AND (`pwm_cnt` < `eff_duty`).
  - If `breathe_en`=0: `led_out[i]` <= `led_in_q[i]`.
  - Latency from `led_in` to `led_out` is 2 clocks.
- **Duty edge cases:**
  - `eff_duty`=0 gives constant off.
  - `eff_duty`=max gives on for 255 of every 256 clocks (PWM_BITS=8).
- **Simultaneous events:** a `step` in the same cycle as `breathe_en` falling is ignored; the force-to-RAMP_UP wins.
- **Outputs:** `duty` and `phase` are the live registers; no extra latency.

Optional Feature:
- Macro: `LED_BREATHE_GAMMA_EN`.
- **Defined:** `eff_duty` = (`duty` × `duty`) >> PWM_BITS, an approximate gamma-2 perceptual curve. Requires a PWM_BITS×PWM_BITS multiply, truncated. Example at PWM_BITS=8: duty=128 gives eff 64; duty=255 gives eff 254.
- **Undefined:** `eff_duty` = `duty` (linear). No multiplier is synthesised.
- The `duty` port always shows the pre-gamma value.

Decomposition:
- **Shared package `led_pkg`:**
  - Phase encodings RAMP_UP/HOLD_HI/RAMP_DOWN/HOLD_LO.
  - LED count constant (4).
  - Board clock constant CLK_HZ=25_000_000.
- **Sub-module `tick_gen`** (parameter DIV; ports `clk`, `rst`, `clr`, `tick`) implements the step prescaler. It is reusable by the blink stage.

Test Plan:
Bench parameters: PWM_BITS=4, STEP_TICKS=4, HOLD_STEPS=2; gamma macro off unless stated.
1. **Reset:** rst=1 for 3 clks with `led_in`=4'hF → `led_out`=0, `duty`=0, `phase`=0. After release, first `duty`=1 appears exactly 4 clks later.
2. **Full envelope:** `breathe_en`=1, `led_in`=4'hF → `duty` climbs 0→15 over 60 clks, `phase`=1 for 8 clks, ramps 15→0 over 60 clks, `phase`=3 for 8 clks, then repeats. Envelope period is 136 clks.
3. **PWM ratio:** freeze at `duty`=5 (sample during RAMP_UP) → each `led_out` bit is high 5 of every 16 clks. With `led_in`=4'b0101, `led_out`[3] and `led_out`[1] stay 0.
4. **Pass-through:** `breathe_en`=0, `led_in` toggles 4'h0→4'hA → `led_out`=4'hA exactly 2 clks later; `duty` held 0, `phase`=0.
5. **Mid-ramp disable/reset:** drop `breathe_en` at `duty`=9 → next cycle `duty`=0, `phase`=0. Assert rst during HOLD_HI → next cycle all state is at reset values.
6. **Gamma** (LED_BREATHE_GAMMA_EN defined): `duty`=8 → eff 4, `led_out` high 4 of 16 clks; `duty`=15 → eff 14.
